// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter that shares one combinational ALU, with a programmable settle time.
// Optional ALU_ARB_ILLEGAL_OP_EN: reject SELECT[2]=1 operations with an error response.
module alu_share_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [DATA_WIDTH-1:0] req0_data1_i,
  input  logic [DATA_WIDTH-1:0] req0_data2_i,
  input  logic [2:0]            req0_select_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [DATA_WIDTH-1:0] req1_data1_i,
  input  logic [DATA_WIDTH-1:0] req1_data2_i,
  input  logic [2:0]            req1_select_i,
  output logic                  rsp0_valid_o,
  output logic                  rsp1_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_result_o,
  output logic                  rsp_zero_o,
  output logic                  rsp_err_o,
  output logic [DATA_WIDTH-1:0] alu_data1_o,
  output logic [DATA_WIDTH-1:0] alu_data2_o,
  output logic [2:0]            alu_select_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  alu_zero_i,
  output logic                  busy_o
);
  // state  | meaning
  // IDLE   | waiting for a request; READY offered to the granted requester
  // SETTLE | operands driven to the ALU, counting down the settle time
  // DONE   | one-cycle response pulse to the owner
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_e;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  last_q;
  logic                  owner_q;
  logic [DATA_WIDTH-1:0] alu_d1_q, alu_d2_q, res_q;
  logic [2:0]            alu_sel_q;
  logic                  zero_q, rsp0_q, rsp1_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic                  err_q;
`endif

  logic                  gnt0, gnt1, xfer, win, illegal;
  logic [DATA_WIDTH-1:0] win_d1, win_d2;
  logic [2:0]            win_sel;

  // Tie goes to the requester that did not win last time.
  always_comb begin
    gnt0    = req0_valid_i & (~req1_valid_i | last_q);
    gnt1    = req1_valid_i & (~req0_valid_i | ~last_q);
    xfer    = (state_q == IDLE) & (gnt0 | gnt1);
    win     = gnt1;
    win_d1  = win ? req1_data1_i  : req0_data1_i;
    win_d2  = win ? req1_data2_i  : req0_data2_i;
    win_sel = win ? req1_select_i : req0_select_i;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    illegal = win_sel[2];
`else
    illegal = 1'b0;
`endif
  end

  // READY is masked by reset so every output reads 0 while reset is held.
  assign req0_ready_o = rst_n_i & (state_q == IDLE) & gnt0;
  assign req1_ready_o = rst_n_i & (state_q == IDLE) & gnt1;
  assign busy_o       = (state_q != IDLE);
  assign rsp0_valid_o = rsp0_q;
  assign rsp1_valid_o = rsp1_q;
  assign rsp_result_o = res_q;
  assign rsp_zero_o   = zero_q;
  assign alu_data1_o  = alu_d1_q;
  assign alu_data2_o  = alu_d2_q;
  assign alu_select_o = alu_sel_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  assign rsp_err_o    = err_q;
`else
  assign rsp_err_o    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      alu_d1_q  <= '0;
      alu_d2_q  <= '0;
      alu_sel_q <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      rsp0_q    <= 1'b0;
      rsp1_q    <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
      err_q     <= 1'b0;
`endif
    end else begin
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            owner_q <= win;
            last_q  <= win;
            if (illegal) begin
              // Rejected op never reaches the ALU; respond immediately.
              res_q   <= '0;
              zero_q  <= 1'b0;
              rsp0_q  <= ~win;
              rsp1_q  <= win;
`ifdef ALU_ARB_ILLEGAL_OP_EN
              err_q   <= 1'b1;
`endif
              state_q <= DONE;
            end else begin
              alu_d1_q  <= win_d1;
              alu_d2_q  <= win_d2;
              alu_sel_q <= win_sel;
              cnt_q     <= SETTLE_INIT;
              state_q   <= SETTLE;
            end
          end
        end
        SETTLE: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            res_q   <= alu_result_i;
            zero_q  <= alu_zero_i;
            rsp0_q  <= ~owner_q;
            rsp1_q  <= owner_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            err_q   <= 1'b0;
`endif
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: randomized requests against a cycle-level reference model.
module tb_alu_share_arbiter;
  localparam int S1 = 1;
  localparam int S3 = 3;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // DUT A (settle 1)
  logic [1:0] v;
  logic [7:0] d1 [2];
  logic [7:0] d2 [2];
  logic [2:0] sel [2];
  logic       rdy0, rdy1, rsp0, rsp1, rzero, rerr, busy, azero;
  logic [7:0] rres, ad1, ad2, ares;
  logic [2:0] asel;

  // DUT B (settle 3)
  logic       b_v0;
  logic [7:0] b_d1, b_d2;
  logic [2:0] b_sel;
  logic       b_rdy0, b_rdy1, b_rsp0, b_rsp1, b_rzero, b_rerr, b_busy, b_azero;
  logic [7:0] b_rres, b_ad1, b_ad2, b_ares;
  logic [2:0] b_asel;

  function automatic logic [8:0] alu_f(logic [2:0] s, logic [7:0] a, logic [7:0] b);
    logic [7:0] r;
    case (s)
      3'b000:  r = b;
      3'b001:  r = a + b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      default: r = ~a;
    endcase
    return {(r == 8'h00), r};
  endfunction

  assign {azero, ares}     = alu_f(asel, ad1, ad2);
  assign {b_azero, b_ares} = alu_f(b_asel, b_ad1, b_ad2);

  alu_share_arbiter #(.DATA_WIDTH(8), .SETTLE_CYCLES(S1)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_valid_i(v[0]), .req0_ready_o(rdy0), .req0_data1_i(d1[0]), .req0_data2_i(d2[0]), .req0_select_i(sel[0]),
    .req1_valid_i(v[1]), .req1_ready_o(rdy1), .req1_data1_i(d1[1]), .req1_data2_i(d2[1]), .req1_select_i(sel[1]),
    .rsp0_valid_o(rsp0), .rsp1_valid_o(rsp1), .rsp_result_o(rres), .rsp_zero_o(rzero), .rsp_err_o(rerr),
    .alu_data1_o(ad1), .alu_data2_o(ad2), .alu_select_o(asel), .alu_result_i(ares), .alu_zero_i(azero),
    .busy_o(busy));

  alu_share_arbiter #(.DATA_WIDTH(8), .SETTLE_CYCLES(S3)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_valid_i(b_v0), .req0_ready_o(b_rdy0), .req0_data1_i(b_d1), .req0_data2_i(b_d2), .req0_select_i(b_sel),
    .req1_valid_i(1'b0), .req1_ready_o(b_rdy1), .req1_data1_i(8'h00), .req1_data2_i(8'h00), .req1_select_i(3'b000),
    .rsp0_valid_o(b_rsp0), .rsp1_valid_o(b_rsp1), .rsp_result_o(b_rres), .rsp_zero_o(b_rzero), .rsp_err_o(b_rerr),
    .alu_data1_o(b_ad1), .alu_data2_o(b_ad2), .alu_select_o(b_asel), .alu_result_i(b_ares), .alu_zero_i(b_azero),
    .busy_o(b_busy));

  typedef struct {
    logic       owner;
    logic [7:0] res;
    logic       zero;
    logic       err;
  } exp_t;
  exp_t q[$];

  int   checks = 0;
  int   failures = 0;
  // Reference model: who won last, cycles left until idle, last opcode issued to the ALU.
  logic       last;
  int         bc;
  logic [1:0] served;
  logic [2:0] last_sel;
  bit         mon_en = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Entered and left at a falling edge.
  task automatic cycle(int prob);
    int   g;
    exp_t e;
    logic [8:0] r;
    v = v & ~served;
    served = 2'b00;
    chk("busy", busy, bc != 0);
    chk("rsp_pulse_timing", rsp0 | rsp1, bc == 1);
    for (int n = 0; n < 2; n++) begin
      if (!v[n] && $urandom_range(99) < prob) begin
        v[n]   = 1'b1;
        sel[n] = 3'($urandom_range(3));
        d1[n]  = 8'($urandom);
        d2[n]  = 8'($urandom);
      end else if (v[n] && prob > 0 && $urandom_range(3) == 0) begin
        d2[n] = 8'($urandom);
      end
    end
    #1;
    g = -1;
    if (bc == 0) begin
      if (v[0] && v[1]) g = last ? 0 : 1;
      else if (v[0])    g = 0;
      else if (v[1])    g = 1;
    end
    chk("ready0", rdy0, g == 0);
    chk("ready1", rdy1, g == 1);
    @(posedge clk);
    if (g >= 0) begin
      e.owner = (g == 1);
      if (ILL && sel[g][2]) begin
        e.res = 8'h00; e.zero = 1'b0; e.err = 1'b1;
        bc = 1;
      end else begin
        r = alu_f(sel[g], d1[g], d2[g]);
        e.res = r[7:0]; e.zero = r[8]; e.err = 1'b0;
        last_sel = sel[g];
        bc = S1 + 1;
      end
      q.push_back(e);
      last = (g == 1);
      served[g] = 1'b1;
    end else if (bc > 0) begin
      bc--;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int k = 0;
    while ((v != 2'b00 || bc != 0) && k < 50) begin
      cycle(0);
      k++;
    end
    chk("drain_within_budget", k < 50, 1);
  endtask

  task automatic model_reset();
    q.delete();
    bc = 0; last = 1'b1; served = 2'b00; last_sel = 3'b000;
    v = 2'b00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expected response per observed pulse.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && (rsp0 || rsp1)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual=%b%b required=none t=%0t", rsp1, rsp0, $time);
      end else begin
        e = q.pop_front();
        chk("rsp_owner", {rsp1, rsp0}, {e.owner, ~e.owner});
        chk("rsp_result", rres, e.res);
        chk("rsp_zero", rzero, e.zero);
        chk("rsp_err", rerr, e.err);
      end
    end
  end

  initial begin
    int edges;
    rst_n = 1'b0;
    model_reset();
    b_v0 = 1'b0; b_d1 = 8'h00; b_d2 = 8'h00; b_sel = 3'b000;
    for (int n = 0; n < 2; n++) begin d1[n] = 8'h00; d2[n] = 8'h00; sel[n] = 3'b000; end
    v[0] = 1'b1;
    #12;
    chk("reset_ready_masked", rdy0, 0);
    chk("reset_outputs", {busy, rsp0, rsp1, rres, rzero, rerr, ad1, ad2, asel}, 0);
    v = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Single add from requester 0.
    v[0] = 1'b1; sel[0] = 3'b001; d1[0] = 8'h05; d2[0] = 8'h03;
    drain();
    chk("t1_result", rres, 8'h08);
    chk("t1_zero", rzero, 0);

    // Both valid right after reset: requester 0 first.
    do_reset();
    v = 2'b11;
    sel[0] = 3'b010; d1[0] = 8'h0F; d2[0] = 8'hF0;
    sel[1] = 3'b011; d1[1] = 8'hA0; d2[1] = 8'h05;
    drain();
    chk("t2_last_result", rres, 8'hA5);

    // Saturated contention, then randomized traffic.
    for (int i = 0; i < 20; i++) cycle(100);
    for (int i = 0; i < 400; i++) cycle(40);
    drain();

    // Reset while requester 1's mov is settling.
    v[1] = 1'b1; sel[1] = 3'b000; d1[1] = 8'h33; d2[1] = 8'h7E;
    for (int k = 0; k < 10 && served[1] == 1'b0; k++) cycle(0);
    chk("mov_issued_data2", ad2, 8'h7E);
    chk("mov_in_settle", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {busy, rdy0, rdy1, rsp0, rsp1, rres, rzero, rerr, ad1, ad2, asel}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(0);

    // Reserved opcode 101.
    v[0] = 1'b1; sel[0] = 3'b001; d1[0] = 8'h10; d2[0] = 8'h22;
    drain();
    v[0] = 1'b1; sel[0] = 3'b101; d1[0] = 8'h3C; d2[0] = 8'h11;
    for (int k = 0; k < 10 && served[0] == 1'b0; k++) cycle(0);
    chk("reserved_alu_select", asel, ILL ? 3'b001 : 3'b101);
    chk("reserved_alu_select_model", asel, last_sel);
    drain();
    chk("reserved_err_flag", rerr, ILL);
    v[1] = 1'b1; sel[1] = 3'b011; d1[1] = 8'h01; d2[1] = 8'h02;
    drain();
    chk("err_cleared_by_legal", rerr, 0);

    // Settle of 3 on the second instance: 0xFF + 0x01.
    b_v0 = 1'b1; b_sel = 3'b001; b_d1 = 8'hFF; b_d2 = 8'h01;
    #1;
    chk("b_ready0", b_rdy0, 1);
    @(posedge clk);
    #1;
    b_v0 = 1'b0;
    edges = 0;
    while (edges < 20 && !b_rsp0) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("b_edges_after_accept", edges, S3);
    chk("b_result", b_rres, 8'h00);
    chk("b_zero", b_rzero, 1);
    @(posedge clk);
    #1;
    chk("b_pulse_one_cycle", {b_rsp0, b_rsp1, b_busy}, 0);
    @(negedge clk);

    chk("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
